shadow_scan_ctrl: RTL and testbench
===================================

Name: shadow_scan_ctrl

Overview:
Sequential replacement for the combinational landing-shadow search. On a request it latches the active tetromino's four cells and scans downward one row offset per cycle against the board. When the first blocked offset is found, it registers the landing (shadow) coordinates and the drop distance, then pulses done. The result feeds the renderer's ghost-piece overlay and the hard-drop logic.

Parameters:
WIDTH, 10, board columns; cell (x,y) maps to board bit index y*WIDTH+x.
HEIGHT, 20, board rows; row HEIGHT-1 is the floor row.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  scan request, sampled at the clock edge
ctrlX1..ctrlX4  input  10 each  active piece cell columns
ctrlY1..ctrlY4  input  10 each  active piece cell rows
boardMemory  input  [0:199]  occupied-cell map, bit y*WIDTH+x, 1 means occupied
shadowX1..shadowX4  output  10 each  landing cell columns, registered
shadowY1..shadowY4  output  10 each  landing cell rows, registered
dropDist  output  5  landing row offset, registered
busy  output  1  high while in SCAN
done  output  1  one-cycle result-valid pulse
err  output  1  invalid coordinates at the last accepted start; held until the next accepted start

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE, d=0, all shadow outputs 0, dropDist 0, busy 0, done 0, err 0.
- States are IDLE and SCAN. busy is high exactly when state is SCAN.
- Accepting a start (start=1 in IDLE, or in SCAN):
  - latch the 8 coordinates, set d=1, clear err, enter SCAN.
- Invalid start: if any latched X ≥ WIDTH or any Y ≥ HEIGHT:
  - skip SCAN and stay in IDLE;
  - shadow outputs = latched coordinates, dropDist=0, err=1;
  - done pulses in the next cycle.
- Blocked(d) is true if, for any cell i, Yi+d ≥ HEIGHT or boardMemory[(Yi+d)*WIDTH+Xi]=1.
  - The range test takes priority; no board bit is read for an out-of-range row.
  - Arithmetic is in at least 10 bits, so there is no wrap.
- Each SCAN edge:
  - if Blocked(d): shadowXi = Xi, shadowYi = Yi+d-1, dropDist = d-1; done=1 in the following cycle; go to IDLE.
  - otherwise: d = d+1.
- Latency: the first blocked offset k is reached after k SCAN edges; done is high during the cycle after the k-th edge.
  - k ≤ HEIGHT, so the worst case is 20 cycles.
- boardMemory is sampled live on each SCAN cycle and is not latched. Board changes mid-scan affect only the offsets not yet tested.
- start during SCAN aborts the current scan and restarts from d=1 with the new coordinates. The aborted scan produces no done.
- start in the same cycle that done is high is accepted normally.
- Outputs hold their values between scans. done is never high for 2 consecutive cycles unless two starts were accepted.
- Asserting rst_n mid-scan returns the block to reset values immediately; no done follows.

Optional Feature:
SHADOW_SCAN_FAST_EN
- Defined: each SCAN edge tests both d and d+1.
  - If Blocked(d): result is offset d-1.
  - Else if Blocked(d+1): result is offset d.
  - Else d = d+2.
  - Worst-case latency is 10 cycles; results are identical to the undefined build.
- Undefined: one offset is tested per cycle, as described above.

Test Plan:
1. Empty board, O-piece cells (4,0),(5,0),(4,1),(5,1), start -> done after 19 SCAN edges (10 with FAST), shadowY=18,18,19,19, shadowX unchanged, dropDist=18, err=0.
2. Board bit 104 set (row 10, col 4), vertical I at X=4, Y=0..3 -> blocked at d=7, shadowY=6,7,8,9, dropDist=6, done after 7 edges (4 with FAST).
3. Cell at Y=19, others Y=18..16 -> blocked at d=1, dropDist=0, shadow equals the input, done after 1 edge.
4. Empty board, start with X=0 then start again on SCAN edge 3 with X=7 -> exactly one done, shadowX=7 and Y results for the second piece.
5. rst_n low on SCAN edge 5 -> busy=0, done=0 and all outputs 0 immediately; no done for 25 cycles after release.
6. ctrlY2=20 at start -> no SCAN, err=1, done 1 cycle later, shadow equals the input, dropDist=0.

Source files
------------

// File: rtl/shadow_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shadow_scan_ctrl
//  Purpose  : Sequential landing-shadow search. Latches the active piece's
//             four cells on start, walks downward one row offset per cycle
//             against the live board, and registers the landing coordinates
//             and drop distance when the first blocked offset is found.
//  Options  : `define SHADOW_SCAN_FAST_EN to test two offsets per cycle
//             (d and d+1). The results are the same; latency is halved.
//  Revision : 1.0  initial release
// ============================================================================
module shadow_scan_ctrl #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [9:0]              ctrlX1,
  input  logic [9:0]              ctrlX2,
  input  logic [9:0]              ctrlX3,
  input  logic [9:0]              ctrlX4,
  input  logic [9:0]              ctrlY1,
  input  logic [9:0]              ctrlY2,
  input  logic [9:0]              ctrlY3,
  input  logic [9:0]              ctrlY4,
  input  logic [0:WIDTH*HEIGHT-1] boardMemory,
  output logic [9:0]              shadowX1,
  output logic [9:0]              shadowX2,
  output logic [9:0]              shadowX3,
  output logic [9:0]              shadowX4,
  output logic [9:0]              shadowY1,
  output logic [9:0]              shadowY2,
  output logic [9:0]              shadowY3,
  output logic [9:0]              shadowY4,
  output logic [4:0]              dropDist,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int          IDX_W       = $clog2(WIDTH * HEIGHT);
  localparam logic [9:0]  c_width_10  = 10'(WIDTH);
  localparam logic [9:0]  c_height_10 = 10'(HEIGHT);
  localparam logic [10:0] c_height_11 = 11'(HEIGHT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] d_q, d_d;
  logic [9:0] x_q   [4];
  logic [9:0] x_d   [4];
  logic [9:0] y_q   [4];
  logic [9:0] y_d   [4];
  logic [9:0] shx_q [4];
  logic [9:0] shx_d [4];
  logic [9:0] shy_q [4];
  logic [9:0] shy_d [4];
  logic [4:0] drop_q, drop_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [9:0] in_x [4];
  logic [9:0] in_y [4];
  logic       in_bad;
  logic       blk_lo;
  logic       land;
  logic [4:0] land_off;

  assign in_x[0] = ctrlX1;
  assign in_x[1] = ctrlX2;
  assign in_x[2] = ctrlX3;
  assign in_x[3] = ctrlX4;
  assign in_y[0] = ctrlY1;
  assign in_y[1] = ctrlY2;
  assign in_y[2] = ctrlY3;
  assign in_y[3] = ctrlY4;

  // A cell row past the floor counts as blocked without touching the board,
  // so the board index is only formed for in-range rows.
  function automatic logic piece_blocked(
    input logic [9:0]              px [4],
    input logic [9:0]              py [4],
    input logic [4:0]              off,
    input logic [0:WIDTH*HEIGHT-1] board
  );
    logic             hit;
    logic [10:0]      row;
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      row = {1'b0, py[i]} + {6'b0, off};
      if (row >= c_height_11) begin
        hit = 1'b1;
      end else begin
        idx = IDX_W'(row) * IDX_W'(WIDTH) + IDX_W'(px[i]);
        if (board[idx]) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Flag a request whose coordinates fall outside the board.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (in_x[i] >= c_width_10 || in_y[i] >= c_height_10) in_bad = 1'b1;
    end
  end

  assign blk_lo = piece_blocked(x_q, y_q, d_q, boardMemory);

`ifdef SHADOW_SCAN_FAST_EN
  logic blk_hi;
  assign blk_hi = piece_blocked(x_q, y_q, d_q + 5'd1, boardMemory);
`endif

  // Next-state: request acceptance (also aborts a running scan), offset walk,
  // and landing capture.
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    x_d      = x_q;
    y_d      = y_q;
    shx_d    = shx_q;
    shy_d    = shy_q;
    drop_d   = drop_q;
    done_d   = 1'b0;
    err_d    = err_q;
    land     = 1'b0;
    land_off = '0;

    if (start) begin
      x_d = in_x;
      y_d = in_y;
      d_d = 5'd1;
      if (in_bad) begin
        state_d = ST_IDLE;
        shx_d   = in_x;
        shy_d   = in_y;
        drop_d  = '0;
        err_d   = 1'b1;
        done_d  = 1'b1;
      end else begin
        state_d = ST_SCAN;
        err_d   = 1'b0;
      end
    end else if (state_q == ST_SCAN) begin
`ifdef SHADOW_SCAN_FAST_EN
      if (blk_lo) begin
        land     = 1'b1;
        land_off = d_q - 5'd1;
      end else if (blk_hi) begin
        land     = 1'b1;
        land_off = d_q;
      end else begin
        d_d = d_q + 5'd2;
      end
`else
      if (blk_lo) begin
        land     = 1'b1;
        land_off = d_q - 5'd1;
      end else begin
        d_d = d_q + 5'd1;
      end
`endif
      if (land) begin
        state_d = ST_IDLE;
        drop_d  = land_off;
        done_d  = 1'b1;
        for (int i = 0; i < 4; i++) begin
          shx_d[i] = x_q[i];
          shy_d[i] = y_q[i] + {5'b0, land_off};
        end
      end
    end
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        shx_q[i] <= '0;
        shy_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) begin
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        shx_q[i] <= shx_d[i];
        shy_q[i] <= shy_d[i];
      end
    end
  end

  assign shadowX1 = shx_q[0];
  assign shadowX2 = shx_q[1];
  assign shadowX3 = shx_q[2];
  assign shadowX4 = shx_q[3];
  assign shadowY1 = shy_q[0];
  assign shadowY2 = shy_q[1];
  assign shadowY3 = shy_q[2];
  assign shadowY4 = shy_q[3];
  assign dropDist = drop_q;
  assign busy     = (state_q == ST_SCAN);
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shadow_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_shadow_scan_ctrl
//  Purpose  : Self-checking bench for shadow_scan_ctrl. Directed scenarios
//             plus randomized boards/pieces checked against a row-walk model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shadow_scan_ctrl;

  localparam int W = 10;
  localparam int H = 20;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [9:0]     cx [4];
  logic [9:0]     cy [4];
  logic [0:W*H-1] board;
  logic [9:0]     sx1, sx2, sx3, sx4, sy1, sy2, sy3, sy4;
  logic [4:0]     drop;
  logic           busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;

  shadow_scan_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ctrlX1(cx[0]), .ctrlX2(cx[1]), .ctrlX3(cx[2]), .ctrlX4(cx[3]),
    .ctrlY1(cy[0]), .ctrlY2(cy[1]), .ctrlY3(cy[2]), .ctrlY4(cy[3]),
    .boardMemory(board),
    .shadowX1(sx1), .shadowX2(sx2), .shadowX3(sx3), .shadowX4(sx4),
    .shadowY1(sy1), .shadowY2(sy2), .shadowY3(sy3), .shadowY4(sy4),
    .dropDist(drop), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  wire [39:0] got_x = {sx1, sx2, sx3, sx4};
  wire [39:0] got_y = {sy1, sy2, sy3, sy4};

  // First offset d>=1 at which any cell would leave the board or hit a block.
  function automatic int model_k(input int px[4], input int py[4], input logic [0:W*H-1] b);
    for (int d = 1; d <= H; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (py[i] + d >= H) return d;
        if (b[(py[i] + d) * W + px[i]]) return d;
      end
    end
    return H;
  endfunction

  function automatic logic [39:0] pack4(input int v[4]);
    return {10'(v[0]), 10'(v[1]), 10'(v[2]), 10'(v[3])};
  endfunction

  function automatic int exp_edges(input int k);
`ifdef SHADOW_SCAN_FAST_EN
    return (k + 1) / 2;
`else
    return k;
`endif
  endfunction

  // Called at a negedge; start is sampled at the next posedge, returns at the negedge after it.
  task automatic drive_start(input int px[4], input int py[4]);
    for (int i = 0; i < 4; i++) begin
      cx[i] = 10'(px[i]);
      cy[i] = 10'(py[i]);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = done;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    board = '0;
    for (int i = 0; i < 4; i++) begin cx[i] = '0; cy[i] = '0; end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, err, drop, got_x, got_y} !== '0)
      $display("FAIL reset_values: got busy=%b done=%b err=%b drop=%0d x=%h y=%h, want all 0", busy, done, err, drop, got_x, got_y);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_landing();
    int px[4], py[4], ey[4];
    int want_k[3] = '{19, 7, 1};
    int cyc;
    bit seen;
    for (int c = 0; c < 3; c++) begin
      board = '0;
      case (c)
        0:       begin px = '{4, 5, 4, 5}; py = '{0, 0, 1, 1}; end
        1:       begin px = '{4, 4, 4, 4}; py = '{0, 1, 2, 3}; board[104] = 1'b1; end
        default: begin px = '{2, 2, 2, 2}; py = '{19, 18, 17, 16}; end
      endcase
      for (int i = 0; i < 4; i++) ey[i] = py[i] + want_k[c] - 1;
      drive_start(px, py);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL land%0d_busy: got %b want 1", c, busy);
      else n_pass++;
      wait_done(cyc, seen);
      n_checks++;
      if (!seen || cyc != exp_edges(want_k[c]))
        $display("FAIL land%0d_latency: got seen=%b edges=%0d want %0d", c, seen, cyc, exp_edges(want_k[c]));
      else n_pass++;
      n_checks++;
      if (drop !== 5'(want_k[c] - 1)) $display("FAIL land%0d_drop: got %0d want %0d", c, drop, want_k[c] - 1);
      else n_pass++;
      n_checks++;
      if (got_x !== pack4(px)) $display("FAIL land%0d_x: got %h want %h", c, got_x, pack4(px));
      else n_pass++;
      n_checks++;
      if (got_y !== pack4(ey)) $display("FAIL land%0d_y: got %h want %h", c, got_y, pack4(ey));
      else n_pass++;
      n_checks++;
      if (err !== 1'b0) $display("FAIL land%0d_err: got %b want 0", c, err);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) $display("FAIL land%0d_pulse: got done=%b busy=%b want 0 0", c, done, busy);
      else n_pass++;
    end
  endtask

  task automatic test_live_board();
    int px[4] = '{4, 5, 4, 5};
    int py[4] = '{0, 0, 1, 1};
    int cyc;
    bit seen;
    board = '0;
    drive_start(px, py);
    repeat (2) @(negedge clk);
    board[24]  = 1'b1;   // row 2: offsets reaching it are already behind the scan
    board[104] = 1'b1;   // row 10: first hit at offset 9
    wait_done(cyc, seen);
    n_checks++;
    if (!seen || cyc + 2 != exp_edges(9))
      $display("FAIL live_latency: got seen=%b edges=%0d want %0d", seen, cyc + 2, exp_edges(9));
    else n_pass++;
    n_checks++;
    if (drop !== 5'd8) $display("FAIL live_drop: got %0d want 8", drop);
    else n_pass++;
    n_checks++;
    if (got_y !== {10'd8, 10'd8, 10'd9, 10'd9}) $display("FAIL live_y: got %h want 8,8,9,9", got_y);
    else n_pass++;
    @(negedge clk);
    board = '0;
  endtask

  task automatic test_restart();
    int pa[4] = '{0, 0, 0, 0};
    int ya[4] = '{0, 1, 2, 3};
    int pb[4] = '{7, 8, 7, 8};
    int yb[4] = '{5, 5, 6, 6};
    int ndone = 0;
    int first = -1;
    logic [39:0] cap_x = '0, cap_y = '0;
    logic [4:0]  cap_d = '0;
    board = '0;
    drive_start(pa, ya);
    repeat (2) @(negedge clk);
    drive_start(pb, yb);
    for (int t = 0; t < 40; t++) begin
      if (done) begin
        ndone++;
        if (first < 0) begin first = t; cap_x = got_x; cap_y = got_y; cap_d = drop; end
      end
      @(negedge clk);
    end
    n_checks++;
    if (ndone != 1) $display("FAIL restart_count: got %0d dones want 1", ndone);
    else n_pass++;
    n_checks++;
    if (first != exp_edges(14)) $display("FAIL restart_latency: got %0d want %0d", first, exp_edges(14));
    else n_pass++;
    n_checks++;
    if (cap_x !== pack4(pb)) $display("FAIL restart_x: got %h want %h", cap_x, pack4(pb));
    else n_pass++;
    n_checks++;
    if (cap_y !== {10'd18, 10'd18, 10'd19, 10'd19}) $display("FAIL restart_y: got %h want 18,18,19,19", cap_y);
    else n_pass++;
    n_checks++;
    if (cap_d !== 5'd13) $display("FAIL restart_drop: got %0d want 13", cap_d);
    else n_pass++;
  endtask

  task automatic test_midscan_reset();
    int px[4] = '{4, 5, 4, 5};
    int py[4] = '{0, 0, 1, 1};
    int ndone = 0;
    int nbusy = 0;
    board = '0;
    drive_start(px, py);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, drop, got_x, got_y} !== '0)
      $display("FAIL midreset_values: got busy=%b done=%b drop=%0d x=%h y=%h want all 0", busy, done, drop, got_x, got_y);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    n_checks++;
    if (ndone != 0 || nbusy != 0) $display("FAIL midreset_quiet: got dones=%0d busy_cycles=%0d want 0 0", ndone, nbusy);
    else n_pass++;
  endtask

  task automatic test_invalid();
    int px[4], py[4];
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin px = '{4, 5, 4, 5}; py = '{0, 20, 1, 1}; end
      else        begin px = '{10, 3, 3, 3}; py = '{2, 3, 4, 5}; end
      drive_start(px, py);
      n_checks++;
      if ({done, busy, err} !== 3'b101) $display("FAIL inv%0d_flags: got done=%b busy=%b err=%b want 1 0 1", c, done, busy, err);
      else n_pass++;
      n_checks++;
      if (got_x !== pack4(px) || got_y !== pack4(py))
        $display("FAIL inv%0d_shadow: got x=%h y=%h want x=%h y=%h", c, got_x, got_y, pack4(px), pack4(py));
      else n_pass++;
      n_checks++;
      if (drop !== 5'd0) $display("FAIL inv%0d_drop: got %0d want 0", c, drop);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, busy, err} !== 3'b001) $display("FAIL inv%0d_after: got done=%b busy=%b err=%b want 0 0 1", c, done, busy, err);
      else n_pass++;
    end
  endtask

  // Each new request is issued in the cycle done is high (back-to-back).
  task automatic test_random();
    int px[4], py[4], ey[4];
    int k, cyc;
    bit seen;
    for (int it = 0; it < 30; it++) begin
      for (int b = 0; b < W * H; b++) board[b] = ($urandom_range(0, 99) < 10);
      for (int i = 0; i < 4; i++) begin
        px[i] = $urandom_range(0, W - 1);
        py[i] = $urandom_range(0, H - 1);
      end
      k = model_k(px, py, board);
      for (int i = 0; i < 4; i++) ey[i] = py[i] + k - 1;
      drive_start(px, py);
      wait_done(cyc, seen);
      n_checks++;
      if (!seen || cyc != exp_edges(k)) $display("FAIL rnd%0d_latency: got seen=%b edges=%0d want %0d", it, seen, cyc, exp_edges(k));
      else n_pass++;
      n_checks++;
      if (drop !== 5'(k - 1)) $display("FAIL rnd%0d_drop: got %0d want %0d", it, drop, k - 1);
      else n_pass++;
      n_checks++;
      if (got_x !== pack4(px) || got_y !== pack4(ey))
        $display("FAIL rnd%0d_shadow: got x=%h y=%h want x=%h y=%h", it, got_x, got_y, pack4(px), pack4(ey));
      else n_pass++;
      n_checks++;
      if (err !== 1'b0) $display("FAIL rnd%0d_err: got %b want 0", it, err);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_landing();
    test_live_board();
    test_restart();
    test_midscan_reset();
    test_invalid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
